// File: rtl/orbit_trig_pkg.sv
// Shared defaults, FSM state type and error-handling limits for orbit_trigger_gen.
package orbit_trig_pkg;

  localparam int unsigned DEF_NBX   = 3564;
  localparam int unsigned DEF_BXW   = 12;
  localparam int unsigned DEF_OW    = 32;
  localparam int unsigned DEF_NTRIG = 4;

  localparam logic [7:0]  ERR_MAX    = 8'd255;
  localparam int unsigned MISS_LIMIT = 3;

  typedef enum logic {
    HUNT,
    LOCKED
  } orbit_state_e;

endpackage

// File: rtl/orbit_trig_chan.sv
// One trigger channel: registered strobe when the ticking bunch counter hits this channel's position.
module orbit_trig_chan
  import orbit_trig_pkg::*;
#(
  parameter int unsigned NBX = DEF_NBX,
  parameter int unsigned BXW = DEF_BXW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic [BXW-1:0] bx_cnt,
  input  logic [BXW-1:0] pos,
  input  logic           en,
  output logic           trig
);

  logic hit;

  // Positions outside the orbit are rejected explicitly, not only by never matching.
  assign hit = tick && en && (pos == bx_cnt) && ({1'b0, pos} < (BXW+1)'(NBX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig <= 1'b0;
    end else begin
      trig <= hit;
    end
  end

endmodule

// File: rtl/orbit_trigger_gen.sv
// Bunch/orbit counter with per-channel bunch triggers.
// Define ORBIT_TRIG_SYNC_EN to build bc0_in alignment (HUNT/LOCKED FSM, error tracking).
module orbit_trigger_gen
  import orbit_trig_pkg::*;
#(
  parameter int unsigned NBX   = DEF_NBX,
  parameter int unsigned BXW   = DEF_BXW,
  parameter int unsigned OW    = DEF_OW,
  parameter int unsigned NTRIG = DEF_NTRIG
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               resync,
  input  logic               bc0_in,
  input  logic               clr_err,
  input  logic [NTRIG*BXW-1:0] trig_pos,
  input  logic [NTRIG-1:0]   trig_en,
  output logic [BXW-1:0]     bx_cnt,
  output logic [OW-1:0]      orbit_cnt,
  output logic               orbit_pulse,
  output logic [NTRIG-1:0]   trig,
  output logic               locked,
  output logic               sync_err,
  output logic [7:0]         err_cnt
);

  logic at_wrap;
  logic count_tick;

  assign at_wrap = (bx_cnt == BXW'(NBX - 1));

`ifdef ORBIT_TRIG_SYNC_EN
  orbit_state_e state;
  logic [1:0]   miss_cnt;
  logic         mismatch;

  assign count_tick = enable && !resync && (state == LOCKED);
  assign mismatch   = count_tick && (bc0_in ^ at_wrap);
  assign locked     = (state == LOCKED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bx_cnt      <= '0;
      orbit_cnt   <= '0;
      orbit_pulse <= 1'b0;
      miss_cnt    <= '0;
      state       <= HUNT;
    end else if (resync) begin
      bx_cnt      <= '0;
      orbit_cnt   <= '0;
      orbit_pulse <= 1'b0;
      miss_cnt    <= '0;
      state       <= HUNT;
    end else begin
      orbit_pulse <= 1'b0;
      case (state)
        HUNT: begin
          bx_cnt <= '0;
          if (enable && bc0_in) state <= LOCKED;
        end
        LOCKED: begin
          if (enable) begin
            // An early bc0_in realigns without counting an orbit.
            if (mismatch && bc0_in) begin
              bx_cnt <= '0;
            end else if (at_wrap) begin
              bx_cnt      <= '0;
              orbit_cnt   <= orbit_cnt + OW'(1);
              orbit_pulse <= 1'b1;
            end else begin
              bx_cnt <= bx_cnt + BXW'(1);
            end
            if (mismatch) begin
              if (miss_cnt == 2'(MISS_LIMIT - 1)) begin
                miss_cnt <= '0;
                bx_cnt   <= '0;
                state    <= HUNT;
              end else begin
                miss_cnt <= miss_cnt + 2'd1;
              end
            end else if (at_wrap) begin
              miss_cnt <= '0;
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_err <= 1'b0;
      err_cnt  <= '0;
    end else if (clr_err) begin
      sync_err <= 1'b0;
      err_cnt  <= '0;
    end else if (mismatch) begin
      sync_err <= 1'b1;
      if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  logic unused_inputs;

  assign unused_inputs = &{1'b0, bc0_in, clr_err};
  assign count_tick    = enable && !resync;
  assign sync_err      = 1'b0;
  assign err_cnt       = '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bx_cnt      <= '0;
      orbit_cnt   <= '0;
      orbit_pulse <= 1'b0;
      locked      <= 1'b0;
    end else begin
      locked      <= 1'b1;
      orbit_pulse <= 1'b0;
      if (resync) begin
        bx_cnt    <= '0;
        orbit_cnt <= '0;
      end else if (enable) begin
        if (at_wrap) begin
          bx_cnt      <= '0;
          orbit_cnt   <= orbit_cnt + OW'(1);
          orbit_pulse <= 1'b1;
        end else begin
          bx_cnt <= bx_cnt + BXW'(1);
        end
      end
    end
  end
`endif

  for (genvar i = 0; i < NTRIG; i++) begin : g_chan
    orbit_trig_chan #(
      .NBX(NBX),
      .BXW(BXW)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .tick   (count_tick),
      .bx_cnt (bx_cnt),
      .pos    (trig_pos[i*BXW +: BXW]),
      .en     (trig_en[i]),
      .trig   (trig[i])
    );
  end

endmodule

// File: tb/tb_orbit_trigger_gen.sv
// Scoreboard bench for orbit_trigger_gen: cycle model expectations queued per step, plus directed checks.
module tb_orbit_trigger_gen;

  localparam int NBX = 3564;
`ifdef ORBIT_TRIG_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, resync, bc0_in, clr_err;
  logic [47:0] trig_pos;
  logic [3:0]  trig_en;
  logic [11:0] bx_cnt;
  logic [31:0] orbit_cnt;
  logic        orbit_pulse;
  logic [3:0]  trig;
  logic        locked, sync_err;
  logic [7:0]  err_cnt;

  orbit_trigger_gen #(
    .NBX(NBX), .BXW(12), .OW(32), .NTRIG(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .resync(resync), .bc0_in(bc0_in),
    .clr_err(clr_err), .trig_pos(trig_pos), .trig_en(trig_en), .bx_cnt(bx_cnt),
    .orbit_cnt(orbit_cnt), .orbit_pulse(orbit_pulse), .trig(trig), .locked(locked),
    .sync_err(sync_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  int          m_bx, m_miss, m_ecnt;
  logic [31:0] m_orb;
  logic        m_pulse, m_st, m_serr;
  logic [3:0]  m_trig;
  logic [63:0] exp_q[$];
  int          ticks;
  int          pulse_ticks[$];
  int          tcnt[4];

  function automatic logic [63:0] dut_obs();
    return {5'b0, bx_cnt, orbit_cnt, orbit_pulse, trig, locked, sync_err, err_cnt};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bx = 0; m_orb = '0; m_pulse = 1'b0; m_trig = '0; m_st = 1'b0;
    m_miss = 0; m_serr = 1'b0; m_ecnt = 0;
  endtask

  task automatic step(input logic en, input logic rs, input logic bc0, input logic clr);
    logic wrap, mm, lk;
    int   p;
    enable = en; resync = rs; bc0_in = bc0; clr_err = clr;
    mm = 1'b0;
    if (rs) begin
      m_bx = 0; m_orb = '0; m_pulse = 1'b0; m_trig = '0; m_st = 1'b0; m_miss = 0;
    end else begin
      m_pulse = 1'b0; m_trig = '0;
      if (SYNC && !m_st) begin
        if (en && bc0) m_st = 1'b1;
      end else if (en) begin
        for (int i = 0; i < 4; i++) begin
          p = int'(trig_pos[i*12 +: 12]);
          m_trig[i] = trig_en[i] && (p == m_bx);
        end
        wrap = (m_bx == NBX - 1);
        mm   = SYNC && (bc0 != wrap);
        if (mm && bc0) m_bx = 0;
        else if (wrap) begin m_bx = 0; m_orb = m_orb + 32'd1; m_pulse = 1'b1; end
        else m_bx = m_bx + 1;
        if (mm) begin
          m_miss = m_miss + 1;
          if (m_miss == 3) begin m_miss = 0; m_st = 1'b0; m_bx = 0; end
        end else if (wrap) m_miss = 0;
      end
    end
    if (SYNC) begin
      if (clr) begin m_serr = 1'b0; m_ecnt = 0; end
      else if (mm) begin m_serr = 1'b1; if (m_ecnt < 255) m_ecnt = m_ecnt + 1; end
    end
    lk = SYNC ? m_st : 1'b1;
    exp_q.push_back({5'b0, 12'(m_bx), m_orb, m_pulse, m_trig, lk, m_serr, 8'(m_ecnt)});
    if (en && !rs) ticks++;
    @(posedge clk);
    #1;
    check("cycle", dut_obs(), exp_q.pop_front());
    if (orbit_pulse) pulse_ticks.push_back(ticks);
    for (int i = 0; i < 4; i++) if (trig[i]) tcnt[i]++;
  endtask

  // Ticks until the model reaches target, keeping bc0_in aligned in the sync build.
  task automatic advance_to(input int target);
    for (int n = 0; n < 2 * NBX && m_bx != target; n++)
      step(1'b1, 1'b0, SYNC && (m_bx == NBX - 1), 1'b0);
    check("advance", 64'(bx_cnt), 64'(target));
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; resync = 1'b0; bc0_in = 1'b0; clr_err = 1'b0;
    trig_pos = {12'd4000, 12'd3563, 12'd127, 12'd0};
    trig_en  = 4'hF;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_obs(), 64'd0);
    reset = 1'b1;

    if (SYNC) begin
      repeat (9) step(1'b1, 1'b0, 1'b0, 1'b0);
      check("hunt_unlocked", 64'(locked), 64'd0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check("lock_tick10", 64'(locked), 64'd1);
    end

    // Two full orbits of continuous ticks
    ticks = 0;
    pulse_ticks.delete();
    for (int i = 0; i < 4; i++) tcnt[i] = 0;
    for (int n = 0; n < 2 * NBX; n++) step(1'b1, 1'b0, SYNC && (m_bx == NBX - 1), 1'b0);
    check("pulse_count", 64'(pulse_ticks.size()), 64'd2);
    if (pulse_ticks.size() == 2) begin
      check("pulse1_tick", 64'(pulse_ticks[0]), 64'd3564);
      check("pulse2_tick", 64'(pulse_ticks[1]), 64'd7128);
    end
    check("orbit_cnt_2", 64'(orbit_cnt), 64'd2);
    check("bx_after_2", 64'(bx_cnt), 64'd0);
    check("trig0_count", 64'(tcnt[0]), 64'd2);
    check("trig1_count", 64'(tcnt[1]), 64'd2);
    check("trig2_count", 64'(tcnt[2]), 64'd2);
    check("trig3_never", 64'(tcnt[3]), 64'd0);
    check("err_cnt_aligned", 64'(err_cnt), 64'd0);

    // Gapped enable; in the free-running build bc0_in/clr_err are noise
    for (int n = 0; n < 300; n++) begin
      if (SYNC) step(1'($urandom_range(1)), 1'b0, 1'b0, 1'b0);
      else step(1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    check("random_sync_err", 64'(sync_err), 64'd0);
    check("random_locked", 64'(locked), 64'd1);

    advance_to(500);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("resync_bx", 64'(bx_cnt), 64'd0);
    check("resync_orbit", 64'(orbit_cnt), 64'd0);

    if (SYNC) begin
      check("resync_hunt", 64'(locked), 64'd0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 3; k++) begin
        advance_to(100);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("mm_sync_err", 64'(sync_err), 64'd1);
        check("mm_err_cnt", 64'(err_cnt), 64'(k));
        check("mm_realign", 64'(bx_cnt), 64'd0);
      end
      check("mm_unlock", 64'(locked), 64'd0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      advance_to(100);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      check("clr_wins_cnt", 64'(err_cnt), 64'd0);
      check("clr_wins_flag", 64'(sync_err), 64'd0);
      for (int r = 0; r < 90; r++) repeat (4) step(1'b1, 1'b0, 1'b1, 1'b0);
      check("err_saturate", 64'(err_cnt), 64'd255);
      step(1'b1, 1'b0, 1'b1, 1'b0);
    end

    // Asynchronous reset mid-orbit, between clock edges
    advance_to(2000);
    #2 reset = 1'b0;
    #1 check("async_rst", dut_obs(), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_held", dut_obs(), 64'd0);
    trig_en = 4'b1110;
    reset   = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("release_no_strobe", 64'({orbit_pulse, trig}), 64'd0);
    repeat (5) step(1'b1, 1'b0, SYNC, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
